// File: rtl/seven_seg_pkg.sv
// Shared constants and elaboration-time helpers for the seven-segment scan driver.
package seven_seg_pkg;

   // Hex nibble -> active-high gfedcba pattern, entry i for nibble value i
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // Clocks spent on one digit per frame
   function automatic int unsigned calc_tick_div(input int unsigned clkspeed,
                                                 input int unsigned refresh_hz,
                                                 input int unsigned digits);
      return clkspeed / (refresh_hz * digits);
   endfunction

   // Clocks per PWM step, never below one
   function automatic int unsigned calc_sub_div(input int unsigned tick_div,
                                                input int unsigned duty_bits);
      int unsigned s;
      s = tick_div >> duty_bits;
      return (s == 0) ? 1 : s;
   endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seven_seg_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern_c
);

   // Table lookup
   assign pattern_c = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_mux.sv
// Multiplexed seven-segment driver: PWM brightness, double-buffered digits,
// selectable pin polarity. Optional leading-zero suppression: SEVEN_SEG_LZS_EN.
module seven_seg_mux
   import seven_seg_pkg::*;
#(
   parameter int unsigned CLKSPEED       = 50000000,
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned REFRESH_HZ     = 1000,
   parameter int unsigned DUTY_BITS      = 3,
   parameter int unsigned SEG_ACTIVE_LOW = 1,
   parameter int unsigned AN_ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic                  load,
   input  logic [DUTY_BITS-1:0]  duty,
   output logic [6:0]            seg,
   output logic                  seg_dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);

   localparam int unsigned TICK_DIV = calc_tick_div(CLKSPEED, REFRESH_HZ, DIGITS);
   localparam int unsigned SUB_DIV  = calc_sub_div(TICK_DIV, DUTY_BITS);
   localparam int unsigned PRESC_W  = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
   localparam int unsigned DIG_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned VAL_W    = 4 * DIGITS;

   localparam logic              SEG_INV = (SEG_ACTIVE_LOW != 0);
   localparam logic              AN_INV  = (AN_ACTIVE_LOW != 0);
   localparam logic [6:0]        SEG_OFF = {7{SEG_INV}};
   localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_INV}};

   logic [PRESC_W-1:0]   presc;
   logic [DUTY_BITS-1:0] pwm;
   logic [DIG_W-1:0]     digit;

   logic [VAL_W-1:0]     pend_value, act_value;
   logic [DIGITS-1:0]    pend_dp, act_dp;
   logic [DIGITS-1:0]    pend_blank, act_blank;

   logic                 presc_tc_c, pwm_wrap_c, dig_last_c, frame_c;
   logic [3:0]           cur_nib_c;
   logic [6:0]           pattern_c;
   logic [DIGITS-1:0]    show_c;
   logic [DIGITS-1:0]    onehot_c;
   logic                 en_c, lit_c, an_en_c, dp_lit_c;
   logic [6:0]           seg_c;

   // Counter terminal conditions; frame boundary is the digit wrap
   assign presc_tc_c = (presc == PRESC_W'(SUB_DIV - 1));
   assign pwm_wrap_c = presc_tc_c && (pwm == '1);
   assign dig_last_c = (digit == DIG_W'(DIGITS - 1));
   assign frame_c    = pwm_wrap_c && dig_last_c;

   // Prescaler, PWM phase and digit index
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
         pwm   <= '0;
         digit <= '0;
      end else begin
         presc <= presc_tc_c ? '0 : presc + PRESC_W'(1);
         if (presc_tc_c) pwm <= pwm + DUTY_BITS'(1);
         if (pwm_wrap_c) digit <= dig_last_c ? '0 : digit + DIG_W'(1);
      end
   end

   // Pending captures on load; active swaps in only at the frame boundary
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_value <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         act_value  <= '0;
         act_dp     <= '0;
         act_blank  <= '0;
      end else begin
         if (load) begin
            pend_value <= value;
            pend_dp    <= dp;
            pend_blank <= blank;
         end
         if (frame_c) begin
            act_value <= pend_value;
            act_dp    <= pend_dp;
            act_blank <= pend_blank;
         end
      end
   end

   assign cur_nib_c = 4'(act_value >> {digit, 2'b00});

   seven_seg_decode u_decode (
      .nibble    (cur_nib_c),
      .pattern_c (pattern_c)
   );

`ifdef SEVEN_SEG_LZS_EN
   // Show digits at or below the highest non-zero nibble; digit 0 always shows
   always_comb begin : lzs
      logic seen;
      seen   = 1'b0;
      show_c = '0;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         seen      = seen | (act_value[4*i +: 4] != 4'h0);
         show_c[i] = seen | (i == 0);
      end
   end
`else
   assign show_c = '1;
`endif

   // Enable for the current digit; a suppressed digit keeps its point lit
   assign onehot_c = DIGITS'(1) << digit;
   assign en_c     = (pwm <= duty) && !act_blank[digit];
   assign lit_c    = en_c && show_c[digit];
   assign dp_lit_c = en_c && act_dp[digit];
   assign an_en_c  = lit_c || dp_lit_c;
   assign seg_c    = lit_c ? pattern_c : 7'h00;

   // Pin registers with polarity applied
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg    <= SEG_OFF;
         seg_dp <= SEG_INV;
         an     <= AN_OFF;
         frame  <= 1'b0;
      end else begin
         seg    <= seg_c ^ SEG_OFF;
         seg_dp <= dp_lit_c ^ SEG_INV;
         an     <= an_en_c ? (onehot_c ^ AN_OFF) : AN_OFF;
         frame  <= frame_c;
      end
   end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux: 4 digits, 8 clocks per digit, 32 per frame.
module tb_seven_seg_mux;

   logic        clk;
   logic        reset;
   logic [15:0] value;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic        load;
   logic [1:0]  duty;
   logic [6:0]  seg;
   logic        seg_dp;
   logic [3:0]  an;
   logic        frame;

   int checks;
   int failures;

   int         cnt  [4];
   logic [6:0] segv [4];
   logic       dpv  [4];
   int         fcnt;

   seven_seg_mux #(
      .CLKSPEED       (3200),
      .DIGITS         (4),
      .REFRESH_HZ     (100),
      .DUTY_BITS      (2),
      .SEG_ACTIVE_LOW (1),
      .AN_ACTIVE_LOW  (1)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .value  (value),
      .dp     (dp),
      .blank  (blank),
      .load   (load),
      .duty   (duty),
      .seg    (seg),
      .seg_dp (seg_dp),
      .an     (an),
      .frame  (frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample one full frame, aligned to the first output cycle of digit 0
   task automatic scan_frame();
      logic [3:0] onehot;
      fcnt = 0;
      for (int d = 0; d < 4; d++) begin
         cnt[d]  = 0;
         segv[d] = 7'h00;
         dpv[d]  = 1'b0;
      end
      for (int i = 0; i < 32; i++) begin
         for (int d = 0; d < 4; d++) begin
            onehot = 4'(1) << d;
            if (an === ~onehot) begin
               cnt[d]++;
               segv[d] = seg;
               dpv[d]  = seg_dp;
            end
         end
         if (frame === 1'b1) fcnt++;
         tick();
      end
   endtask

   // Advance until the frame pulse is visible, bounded
   task automatic wait_frame();
      int n;
      n = 0;
      while (frame !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      check("frame_seen", 32'(frame), 32'd1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      value    = 16'h0000;
      dp       = 4'b0000;
      blank    = 4'b0000;
      load     = 1'b0;
      duty     = 2'd3;
      repeat (3) tick();

      // Reset state
      check("rst_an",     32'(an),     32'hF);
      check("rst_seg",    32'(seg),    32'h7F);
      check("rst_seg_dp", 32'(seg_dp), 32'd1);
      check("rst_frame",  32'(frame),  32'd0);

      // Release and load first data; active stays zero until the first frame
      reset = 1'b0;
      value = 16'h12AF;
      dp    = 4'b0100;
      load  = 1'b1;
      tick();
      load = 1'b0;
      check("f0_an",  32'(an),  32'hE);
      check("f0_seg", 32'(seg), 32'h40);
      repeat (30) tick();
      check("f0_no_frame_31", 32'(frame), 32'd0);
      tick();
      check("f0_frame_32", 32'(frame), 32'd1);
      tick();

      // Full brightness, new data active
      scan_frame();
      check("d3_frames", 32'(fcnt), 32'd1);
      for (int d = 0; d < 4; d++) check($sformatf("d3_cnt%0d", d), 32'(cnt[d]), 32'd8);
      check("d3_seg0", 32'(segv[0]), 32'h0E);
      check("d3_seg1", 32'(segv[1]), 32'h08);
      check("d3_seg2", 32'(segv[2]), 32'h24);
      check("d3_seg3", 32'(segv[3]), 32'h79);
      check("d3_dp0",  32'(dpv[0]),  32'd1);
      check("d3_dp2",  32'(dpv[2]),  32'd0);
      check("d3_dp3",  32'(dpv[3]),  32'd1);

      // Reduced duty
      duty = 2'd1;
      scan_frame();
      for (int d = 0; d < 4; d++) check($sformatf("d1_cnt%0d", d), 32'(cnt[d]), 32'd4);
      duty = 2'd0;
      scan_frame();
      for (int d = 0; d < 4; d++) check($sformatf("d0_cnt%0d", d), 32'(cnt[d]), 32'd2);

      // Blank digit 3
      duty  = 2'd3;
      blank = 4'b1000;
      load  = 1'b1;
      tick();
      load = 1'b0;
      wait_frame();
      tick();
      scan_frame();
      for (int d = 0; d < 3; d++) check($sformatf("bl_cnt%0d", d), 32'(cnt[d]), 32'd8);
      check("bl_cnt3", 32'(cnt[3]), 32'd0);

      // Mid-frame load does not tear the current frame
      repeat (16) tick();
      value = 16'hFFFF;
      blank = 4'b0000;
      load  = 1'b1;
      tick();
      load = 1'b0;
      check("mid_an_old",  32'(an),  32'hB);
      check("mid_seg_old", 32'(seg), 32'h24);
      wait_frame();
      tick();
      check("mid_an_new",  32'(an),  32'hE);
      check("mid_seg_new", 32'(seg), 32'h0E);

      // Load on the frame edge lands one frame late
      repeat (30) tick();
      value = 16'h0123;
      load  = 1'b1;
      tick();
      load = 1'b0;
      check("co_frame", 32'(frame), 32'd1);
      tick();
      check("co_seg_old", 32'(seg), 32'h0E);
      wait_frame();
      tick();
      check("co_seg_new", 32'(seg), 32'h30);

      // Reset mid-frame restarts at digit 0 with cleared buffers
      repeat (5) tick();
      reset = 1'b1;
      #1;
      check("mr_an",     32'(an),     32'hF);
      check("mr_seg",    32'(seg),    32'h7F);
      check("mr_seg_dp", 32'(seg_dp), 32'd1);
      tick();
      reset = 1'b0;
      tick();
      check("mr_an0",  32'(an),  32'hE);
      check("mr_seg0", 32'(seg), 32'h40);

`ifdef SEVEN_SEG_LZS_EN
      // Leading-zero suppression
      value = 16'h0040;
      dp    = 4'b0000;
      blank = 4'b0000;
      duty  = 2'd3;
      load  = 1'b1;
      tick();
      load = 1'b0;
      wait_frame();
      tick();
      scan_frame();
      check("lz_cnt3", 32'(cnt[3]),  32'd0);
      check("lz_cnt2", 32'(cnt[2]),  32'd0);
      check("lz_seg1", 32'(segv[1]), 32'h19);
      check("lz_seg0", 32'(segv[0]), 32'h40);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
